// File: rtl/dcache_pkg.sv
// Shared types and constants for the 2-way set-associative data cache.
// Holds the controller state enum, width constants and address-field helpers.
package dcache_pkg;

    localparam int DC_ADDR_W  = 32;
    localparam int DC_DATA_W  = 32;
    localparam int DC_INDEX_W = 2;
    localparam int DC_TAG_W   = DC_ADDR_W - DC_INDEX_W - 2;
    localparam int DC_SETS    = 1 << DC_INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        WB,
        REFILL,
        ALLOC,
        RESP
    } state_t;

    typedef struct packed {
        logic [DC_TAG_W-1:0]   tag;
        logic [DC_INDEX_W-1:0] index;
        logic [1:0]            offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(
        input logic [DC_ADDR_W-1:0] a
    );
        return addr_fields_t'(a);
    endfunction

    function automatic logic [DC_ADDR_W-1:0] line_addr(
        input logic [DC_TAG_W-1:0]   tag,
        input logic [DC_INDEX_W-1:0] index
    );
        return {tag, index, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Per-set tag/valid/dirty state for both ways plus the per-set LRU bit.
// Ports: clk, rst_n; rd_index -> rd_* (combinational read); one write
// port (wr_en/wr_index/wr_way/wr_tag/wr_valid/wr_dirty) and lru_en/lru_val
// which update the LRU bit of wr_index. Valid/dirty/LRU reset async; tags not.
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int TAG_W   = DC_TAG_W,
    parameter int INDEX_W = DC_INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid0,
    output logic               rd_valid1,
    output logic               rd_dirty0,
    output logic               rd_dirty1,
    output logic [TAG_W-1:0]   rd_tag0,
    output logic [TAG_W-1:0]   rd_tag1,
    output logic               rd_lru,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_way,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_valid,
    input  logic               wr_dirty,
    input  logic               lru_en,
    input  logic               lru_val
);

    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]  valid0_q;
    logic [SETS-1:0]  valid1_q;
    logic [SETS-1:0]  dirty0_q;
    logic [SETS-1:0]  dirty1_q;
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag0_q [SETS];
    logic [TAG_W-1:0] tag1_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid0_q <= '0;
            valid1_q <= '0;
            dirty0_q <= '0;
            dirty1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (wr_en) begin
                if (wr_way) begin
                    valid1_q[wr_index] <= wr_valid;
                    dirty1_q[wr_index] <= wr_dirty;
                end else begin
                    valid0_q[wr_index] <= wr_valid;
                    dirty0_q[wr_index] <= wr_dirty;
                end
            end
            if (lru_en) begin
                lru_q[wr_index] <= lru_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_way) begin
                tag1_q[wr_index] <= wr_tag;
            end else begin
                tag0_q[wr_index] <= wr_tag;
            end
        end
    end

    assign rd_valid0 = valid0_q[rd_index];
    assign rd_valid1 = valid1_q[rd_index];
    assign rd_dirty0 = dirty0_q[rd_index];
    assign rd_dirty1 = dirty1_q[rd_index];
    assign rd_tag0   = tag0_q[rd_index];
    assign rd_tag1   = tag1_q[rd_index];
    assign rd_lru    = lru_q[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Control stage of the 2-way data cache: FSM, data array and miss handling.
// Ports: cpu_req_* / cpu_resp_* CPU side; v_way*/tag_way*/tag_memory to the
// hit stage, hit0/hit1/hit_all back from it; mem_req_* / mem_resp_* memory.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int TAG_W   = DC_TAG_W,
    parameter int INDEX_W = DC_INDEX_W,
    parameter int ADDR_W  = DC_ADDR_W,
    parameter int DATA_W  = DC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              v_way0,
    output logic              v_way1,
    output logic [TAG_W-1:0]  tag_way0,
    output logic [TAG_W-1:0]  tag_way1,
    output logic [TAG_W-1:0]  tag_memory,
    input  logic              hit0,
    input  logic              hit1,
    input  logic              hit_all,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    state_t state_q;
    state_t state_d;

    addr_fields_t in_f;
    logic         offset_unused;

    logic               req_we_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_index_q;
    logic [DATA_W-1:0]  req_wdata_q;
    logic               victim_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               refill_sent_q;

    logic [DATA_W-1:0] data_q [DC_SETS][2];

    logic [INDEX_W-1:0] rd_index;
    logic               t_v0;
    logic               t_v1;
    logic               t_d0;
    logic               t_d1;
    logic [TAG_W-1:0]   t_tag0;
    logic [TAG_W-1:0]   t_tag1;
    logic               t_lru;

    logic               tw_en;
    logic               tw_way;
    logic [TAG_W-1:0]   tw_tag;
    logic               tw_valid;
    logic               tw_dirty;
    logic               lru_en;
    logic               lru_val;
    logic               data_we;
    logic               data_way;
    logic [DATA_W-1:0]  data_wdata;

    logic               hit_way;
    logic               miss_victim;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic               refill_done;

    assign in_f          = split_addr(cpu_req_addr);
    assign offset_unused = ^in_f.offset;

    // Before accept the set comes from the live request so the lookup
    // registers can be loaded on the accept edge.
    assign rd_index = (state_q == IDLE) ? in_f.index : req_index_q;

    dcache_tag_array #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W)
    ) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (rd_index),
        .rd_valid0 (t_v0),
        .rd_valid1 (t_v1),
        .rd_dirty0 (t_d0),
        .rd_dirty1 (t_d1),
        .rd_tag0   (t_tag0),
        .rd_tag1   (t_tag1),
        .rd_lru    (t_lru),
        .wr_en     (tw_en),
        .wr_index  (req_index_q),
        .wr_way    (tw_way),
        .wr_tag    (tw_tag),
        .wr_valid  (tw_valid),
        .wr_dirty  (tw_dirty),
        .lru_en    (lru_en),
        .lru_val   (lru_val)
    );

    // Way0 wins if the hit stage ever flags both ways.
    assign hit_way      = ~hit0;
    assign miss_victim  = !t_v0 ? 1'b0 : (!t_v1 ? 1'b1 : t_lru);
    assign victim_dirty = miss_victim ? (t_v1 & t_d1) : (t_v0 & t_d0);
    assign victim_tag   = victim_q ? t_tag1 : t_tag0;
    assign refill_done  = refill_sent_q & mem_resp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cpu_req_valid) state_d = LOOKUP;
            LOOKUP:  state_d = COMPARE;
            COMPARE: begin
                if (hit_all) begin
                    state_d = RESP;
                end else if (victim_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = req_we_q ? ALLOC : REFILL;
                end
            end
            WB: begin
                if (mem_req_ready) begin
                    state_d = req_we_q ? ALLOC : REFILL;
                end
            end
            REFILL:  if (refill_done) state_d = RESP;
            ALLOC:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready  = rst_n & (state_q == IDLE);
        cpu_resp_valid = (state_q == RESP);
        cpu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        tw_en          = 1'b0;
        tw_way         = 1'b0;
        tw_tag         = req_tag_q;
        tw_valid       = 1'b1;
        tw_dirty       = 1'b0;
        lru_en         = 1'b0;
        lru_val        = 1'b0;
        data_we        = 1'b0;
        data_way       = 1'b0;
        data_wdata     = req_wdata_q;
        unique case (state_q)
            COMPARE: begin
                if (hit_all) begin
                    lru_en  = 1'b1;
                    lru_val = ~hit_way;
                    if (req_we_q) begin
                        tw_en    = 1'b1;
                        tw_way   = hit_way;
                        tw_dirty = 1'b1;
                        data_we  = 1'b1;
                        data_way = hit_way;
                    end
                end
            end
            WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = line_addr(victim_tag, req_index_q);
                mem_req_wdata = data_q[req_index_q][victim_q];
                if (mem_req_ready) begin
                    tw_en  = 1'b1;
                    tw_way = victim_q;
                    tw_tag = victim_tag;
                end
            end
            REFILL: begin
                mem_req_valid = ~refill_sent_q;
                mem_req_addr  = refill_sent_q ? '0
                              : line_addr(req_tag_q, req_index_q);
                if (refill_done) begin
                    tw_en      = 1'b1;
                    tw_way     = victim_q;
                    lru_en     = 1'b1;
                    lru_val    = ~victim_q;
                    data_we    = 1'b1;
                    data_way   = victim_q;
                    data_wdata = mem_resp_rdata;
                end
            end
            ALLOC: begin
                tw_en    = 1'b1;
                tw_way   = victim_q;
                tw_dirty = 1'b1;
                lru_en   = 1'b1;
                lru_val  = ~victim_q;
                data_we  = 1'b1;
                data_way = victim_q;
            end
            RESP: begin
                if (!req_we_q) cpu_resp_rdata = rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_q      <= 1'b0;
            req_tag_q     <= '0;
            req_index_q   <= '0;
            req_wdata_q   <= '0;
            victim_q      <= 1'b0;
            rdata_q       <= '0;
            refill_sent_q <= 1'b0;
            v_way0        <= 1'b0;
            v_way1        <= 1'b0;
            tag_way0      <= '0;
            tag_way1      <= '0;
            tag_memory    <= '0;
        end else begin
            if (state_q == IDLE && cpu_req_valid) begin
                req_we_q    <= cpu_req_we;
                req_tag_q   <= in_f.tag;
                req_index_q <= in_f.index;
                req_wdata_q <= cpu_req_wdata;
                v_way0      <= t_v0;
                v_way1      <= t_v1;
                tag_way0    <= t_tag0;
                tag_way1    <= t_tag1;
                tag_memory  <= in_f.tag;
            end
            if (state_q == COMPARE) begin
                victim_q <= miss_victim;
                if (hit_all && !req_we_q) begin
                    rdata_q <= data_q[req_index_q][hit_way];
                end
            end
            if (state_q == REFILL && refill_done) begin
                rdata_q <= mem_resp_rdata;
            end
            // Marks that the refill read was accepted; now waiting for data.
            refill_sent_q <= (state_q == REFILL)
                           & (refill_sent_q | mem_req_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[req_index_q][data_way] <= data_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a registered hit-stage
// model and a single-requester memory model driven from the request task.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_we = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        v_way0;
    logic        v_way1;
    logic [27:0] tag_way0;
    logic [27:0] tag_way1;
    logic [27:0] tag_memory;
    logic        hit0;
    logic        hit1;
    logic        hit_all;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;

    logic        force_both = 1'b0;
    logic [31:0] tbmem [0:63];

    int checks = 0;
    int passed = 0;

    logic [31:0] rd;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    int          lat;
    int          nw;
    int          nr;

    always #5 clk = ~clk;

    dcache_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .v_way0         (v_way0),
        .v_way1         (v_way1),
        .tag_way0       (tag_way0),
        .tag_way1       (tag_way1),
        .tag_memory     (tag_memory),
        .hit0           (hit0),
        .hit1           (hit1),
        .hit_all        (hit_all),
        .mem_req_valid  (mem_req_valid),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    // Registered tag-compare stage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit0    <= 1'b0;
            hit1    <= 1'b0;
            hit_all <= 1'b0;
        end else if (force_both) begin
            hit0    <= 1'b1;
            hit1    <= 1'b1;
            hit_all <= 1'b1;
        end else begin
            hit0    <= v_way0 && (tag_way0 == tag_memory);
            hit1    <= v_way1 && (tag_way1 == tag_memory);
            hit_all <= (v_way0 && (tag_way0 == tag_memory))
                    || (v_way1 && (tag_way1 == tag_memory));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic run_req(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          wb_stall,
        input  logic [31:0] exp_wb_addr,
        input  logic [31:0] exp_wb_data,
        output logic [31:0] rdata,
        output int          lat_o,
        output int          n_wr,
        output int          n_rd,
        output logic [31:0] wr_addr,
        output logic [31:0] wr_data,
        output logic [31:0] rd_addr
    );
        int          stall;
        int          guard;
        logic        pend;
        logic [31:0] pend_addr;
        rdata = '0;
        lat_o = -1;
        n_wr = 0;
        n_rd = 0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        stall = 0;
        pend = 1'b0;
        pend_addr = '0;
        guard = 0;
        while (!cpu_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
            if (cpu_resp_valid) begin
                lat_o = cyc;
                rdata = cpu_resp_rdata;
                break;
            end
            if (pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = tbmem[pend_addr[7:2]];
                pend = 1'b0;
            end else if (mem_req_valid) begin
                if (mem_req_we && stall < wb_stall) begin
                    checks++;
                    if (mem_req_addr !== exp_wb_addr
                        || mem_req_wdata !== exp_wb_data) begin
                        $display("FAIL wb_stall_hold: addr %h data %h want %h %h",
                                 mem_req_addr, mem_req_wdata,
                                 exp_wb_addr, exp_wb_data);
                    end else begin
                        passed++;
                    end
                    checks++;
                    if (cpu_req_ready !== 1'b0) begin
                        $display("FAIL wb_stall_ready: cpu_req_ready %b want 0",
                                 cpu_req_ready);
                    end else begin
                        passed++;
                    end
                    stall++;
                end else begin
                    mem_req_ready = 1'b1;
                    if (mem_req_we) begin
                        n_wr++;
                        wr_addr = mem_req_addr;
                        wr_data = mem_req_wdata;
                    end else begin
                        n_rd++;
                        rd_addr = mem_req_addr;
                        pend = 1'b1;
                        pend_addr = mem_req_addr;
                    end
                end
            end
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_resp_valid, mem_req_valid, cpu_req_ready, v_way0, v_way1}
            !== 5'b0) begin
            $display("FAIL reset_ctl: resp %b memv %b rdy %b v %b%b want 0",
                     cpu_resp_valid, mem_req_valid, cpu_req_ready,
                     v_way0, v_way1);
        end else begin
            passed++;
        end
        checks++;
        if (tag_memory !== 28'h0 || mem_req_addr !== 32'h0
            || cpu_resp_rdata !== 32'h0) begin
            $display("FAIL reset_data: tagm %h maddr %h rdata %h want 0",
                     tag_memory, mem_req_addr, cpu_resp_rdata);
        end else begin
            passed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_req_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", cpu_req_ready);
        end else begin
            passed++;
        end
    endtask

    task automatic test_load_miss();
        run_req(1'b0, 32'h10, 32'h0, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 5) begin
            $display("FAIL load_miss: rdata %h lat %0d want deadbeef 5", rd, lat);
        end else begin
            passed++;
        end
        checks++;
        if (nr !== 1 || ra !== 32'h10 || nw !== 0) begin
            $display("FAIL load_miss_mem: nr %0d ra %h nw %0d want 1 10 0",
                     nr, ra, nw);
        end else begin
            passed++;
        end
        checks++;
        if (tag_memory !== 28'h1) begin
            $display("FAIL lookup_hold: tag_memory %h want 1", tag_memory);
        end else begin
            passed++;
        end
    endtask

    task automatic test_load_hit();
        run_req(1'b0, 32'h10, 32'h0, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 3 || nw + nr !== 0) begin
            $display("FAIL load_hit: rdata %h lat %0d mem %0d want deadbeef 3 0",
                     rd, lat, nw + nr);
        end else begin
            passed++;
        end
        checks++;
        if (v_way0 !== 1'b1 || tag_way0 !== 28'h1 || v_way1 !== 1'b0) begin
            $display("FAIL lookup_ports: v0 %b t0 %h v1 %b want 1 1 0",
                     v_way0, tag_way0, v_way1);
        end else begin
            passed++;
        end
    endtask

    task automatic test_store_hit();
        run_req(1'b1, 32'h10, 32'h12345678, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (lat !== 3 || nw + nr !== 0 || rd !== 32'h0) begin
            $display("FAIL store_hit: lat %0d mem %0d rdata %h want 3 0 0",
                     lat, nw + nr, rd);
        end else begin
            passed++;
        end
        checks++;
        if (u_dut.u_tags.dirty0_q[0] !== 1'b1) begin
            $display("FAIL store_hit_dirty: got %b want 1",
                     u_dut.u_tags.dirty0_q[0]);
        end else begin
            passed++;
        end
        run_req(1'b0, 32'h10, 32'h0, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (rd !== 32'h12345678 || lat !== 3 || nw + nr !== 0) begin
            $display("FAIL store_then_load: rdata %h lat %0d mem %0d want 12345678 3 0",
                     rd, lat, nw + nr);
        end else begin
            passed++;
        end
    endtask

    task automatic test_store_miss();
        run_req(1'b1, 32'h20, 32'hA5A50020, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (lat !== 4 || nw + nr !== 0) begin
            $display("FAIL store_miss: lat %0d mem %0d want 4 0", lat, nw + nr);
        end else begin
            passed++;
        end
        checks++;
        if (u_dut.u_tags.valid1_q[0] !== 1'b1
            || u_dut.u_tags.lru_q[0] !== 1'b0) begin
            $display("FAIL store_miss_state: v1 %b lru %b want 1 0",
                     u_dut.u_tags.valid1_q[0], u_dut.u_tags.lru_q[0]);
        end else begin
            passed++;
        end
    endtask

    task automatic test_wb_stall();
        run_req(1'b0, 32'h30, 32'h0, 5, 32'h10, 32'h12345678,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (nw !== 1 || wa !== 32'h10 || wd !== 32'h12345678) begin
            $display("FAIL wb_write: nw %0d addr %h data %h want 1 10 12345678",
                     nw, wa, wd);
        end else begin
            passed++;
        end
        checks++;
        if (nr !== 1 || ra !== 32'h30 || rd !== 32'hCAFEF00D || lat !== 11) begin
            $display("FAIL wb_refill: nr %0d ra %h rdata %h lat %0d want 1 30 cafef00d 11",
                     nr, ra, rd, lat);
        end else begin
            passed++;
        end
        checks++;
        if (u_dut.u_tags.dirty0_q[0] !== 1'b0
            || u_dut.u_tags.lru_q[0] !== 1'b1) begin
            $display("FAIL wb_state: dirty0 %b lru %b want 0 1",
                     u_dut.u_tags.dirty0_q[0], u_dut.u_tags.lru_q[0]);
        end else begin
            passed++;
        end
    endtask

    task automatic test_back_to_back();
        run_req(1'b0, 32'h20, 32'h0, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (rd !== 32'hA5A50020 || lat !== 3 || nw + nr !== 0) begin
            $display("FAIL b2b_first: rdata %h lat %0d mem %0d want a5a50020 3 0",
                     rd, lat, nw + nr);
        end else begin
            passed++;
        end
        run_req(1'b0, 32'h30, 32'h0, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (rd !== 32'hCAFEF00D || lat !== 3 || nw + nr !== 0) begin
            $display("FAIL b2b_second: rdata %h lat %0d mem %0d want cafef00d 3 0",
                     rd, lat, nw + nr);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset_midop();
        int guard;
        guard = 0;
        while (!cpu_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 32'h44;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = '0;
        guard = 0;
        while (!(mem_req_valid && !mem_req_we) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (mem_req_addr !== 32'h44) begin
            $display("FAIL midop_req: addr %h want 44", mem_req_addr);
        end else begin
            passed++;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || cpu_resp_valid !== 1'b0) begin
            $display("FAIL midop_wait: memv %b resp %b want 0 0",
                     mem_req_valid, cpu_resp_valid);
        end else begin
            passed++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_dut.state_q !== IDLE || u_dut.u_tags.valid0_q !== 4'b0
            || u_dut.u_tags.valid1_q !== 4'b0 || u_dut.u_tags.lru_q !== 4'b0) begin
            $display("FAIL midop_reset: state %0d v0 %b v1 %b lru %b want 0",
                     u_dut.state_q, u_dut.u_tags.valid0_q,
                     u_dut.u_tags.valid1_q, u_dut.u_tags.lru_q);
        end else begin
            passed++;
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h44444444;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_resp_valid !== 1'b0 || u_dut.state_q !== IDLE
            || mem_req_valid !== 1'b0) begin
            $display("FAIL midop_stray_resp: resp %b state %0d memv %b want 0 0 0",
                     cpu_resp_valid, u_dut.state_q, mem_req_valid);
        end else begin
            passed++;
        end
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        run_req(1'b0, 32'h44, 32'h0, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (nr !== 1 || ra !== 32'h44 || rd !== 32'h44444444 || lat !== 5) begin
            $display("FAIL midop_reload: nr %0d ra %h rdata %h lat %0d want 1 44 44444444 5",
                     nr, ra, rd, lat);
        end else begin
            passed++;
        end
    endtask

    task automatic test_both_hits();
        run_req(1'b1, 32'h54, 32'h55555555, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        checks++;
        if (lat !== 4 || nw + nr !== 0 || u_dut.u_tags.lru_q[1] !== 1'b0) begin
            $display("FAIL both_setup: lat %0d mem %0d lru %b want 4 0 0",
                     lat, nw + nr, u_dut.u_tags.lru_q[1]);
        end else begin
            passed++;
        end
        force_both = 1'b1;
        run_req(1'b0, 32'h54, 32'h0, 0, 32'h0, 32'h0,
                rd, lat, nw, nr, wa, wd, ra);
        force_both = 1'b0;
        checks++;
        if (rd !== 32'h44444444 || lat !== 3
            || u_dut.u_tags.lru_q[1] !== 1'b1) begin
            $display("FAIL both_hits: rdata %h lat %0d lru %b want 44444444 3 1",
                     rd, lat, u_dut.u_tags.lru_q[1]);
        end else begin
            passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            tbmem[i] = 32'h0;
        end
        tbmem[4]  = 32'hDEADBEEF;
        tbmem[12] = 32'hCAFEF00D;
        tbmem[17] = 32'h44444444;
        @(negedge clk);
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_store_miss();
        test_wb_stall();
        test_back_to_back();
        test_reset_midop();
        test_both_hits();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Control stage of the 2-way set-associative data cache, directly downstream of the registered tag-compare (hit) stage.
- Holds the tag, valid, dirty, LRU and data arrays.
- Drives the lookup operands (v_way0/1, tag_way0/1, tag_memory) to the hit stage and consumes the registered hit0/hit1/hit_all one cycle later.
- Serves CPU load/store requests; handles misses with LRU victim selection, dirty write-back and refill over a simple memory handshake.

Parameters:
- TAG_W, 28, tag width; equals ADDR_W - INDEX_W - 2.
- INDEX_W, 2, set-index width; 4 sets, one 32-bit word per line.
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_we  in  1  1=store, 0=load.
- cpu_req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_req_wdata  in  DATA_W  store data.
- cpu_req_ready  out  1  high only in IDLE.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_rdata  out  DATA_W  load data, valid with cpu_resp_valid; 0 for stores.
- v_way0, v_way1  out  1  valid bits of the addressed set, to hit stage.
- tag_way0, tag_way1  out  TAG_W  stored tags of the addressed set.
- tag_memory  out  TAG_W  request tag = addr[ADDR_W-1:INDEX_W+2].
- hit0, hit1, hit_all  in  1  registered hit-stage results.
- mem_req_valid  out  1  memory request.
- mem_req_we  out  1  1=write-back, 0=refill read.
- mem_req_addr  out  ADDR_W  word-aligned address.
- mem_req_wdata  out  DATA_W  write-back data.
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_resp_valid  in  1  refill data valid.
- mem_resp_rdata  in  DATA_W  refill data.

Behaviour:
- Reset, async on rst_n=0:
  - state=IDLE.
  - All valid, dirty and LRU bits = 0.
  - All outputs 0, except cpu_req_ready = 1 once rst_n deasserts.
  - The data array is not reset.
  - Reset mid-operation aborts the transaction: no response, memory request dropped.
- IDLE: cpu_req_ready=1. When cpu_req_valid=1, latch we/addr/wdata and go to LOOKUP.
- LOOKUP (1 cycle): drive the lookup ports from the latched index and tag. The hit stage registers the result at the end of this cycle. Go to COMPARE.
- COMPARE: sample hit0/hit1/hit_all.
  - hit0 and hit1 both high is illegal; way0 takes priority.
  - Read hit: capture the word and update LRU. LRU[set] stores the way *not* used (LRU = 1 - hit way).
  - Write hit: write the word, set dirty, update LRU.
  - Then go to RESP.
  - Miss, victim selection: first invalid way (way0 first); else way LRU[set].
  - Victim valid and dirty: go to WB.
  - Otherwise: a load goes to REFILL; a store goes to ALLOC.
- WB: mem_req_valid=1, we=1, addr={victim tag, index, 2'b00}, wdata=victim word. Hold until mem_req_ready=1. Then clear dirty; a load goes to REFILL, a store goes to ALLOC.
- REFILL:
  - mem_req_valid=1, we=0, addr={req tag, index, 2'b00} until mem_req_ready; then deassert and wait for mem_resp_valid.
  - On mem_resp_valid: write victim way (data, tag, valid=1, dirty=0), update LRU, capture rdata. Go to RESP.
  - mem_resp_valid outside REFILL-wait is ignored.
- ALLOC (store miss, 1 cycle, no fetch since line = 1 word): write victim way (data=wdata, tag, valid=1, dirty=1), update LRU. Go to RESP.
- RESP: cpu_resp_valid=1 for exactly one cycle, then go to IDLE.
- Latencies, counted from the accept edge:
  - Hit: resp in cycle 3.
  - Clean load miss: 3 + memory cycles.
  - Store miss to a clean set: 4.
- Lookup ports are only meaningful in LOOKUP and hold their last value otherwise.
- Requests are never accepted outside IDLE.

Decomposition:
- Package dcache_pkg: state enum (IDLE, LOOKUP, COMPARE, WB, REFILL, ALLOC, RESP), width constants, address-field slice helpers.
- Sub-module dcache_tag_array: per-set tag/valid/dirty for 2 ways plus the LRU bit, with async reset of valid/dirty/LRU. One write port, combinational read by index.
- FSM and data array stay in dcache_ctrl.

Test Plan:
- Load 0x0000_0010 into an empty cache, memory returns 0xDEADBEEF. Expect: mem read addr 0x10, resp rdata 0xDEADBEEF. Then the same load: hit, no mem_req, resp in cycle 3.
- Stores to 0x10 then 0x20 (same set 0, different tags) fill both ways, no memory traffic. Then load 0x30: victim is the LRU way (way0 holding 0x10, dirty). Expect: mem write addr 0x10 with stored data, then refill read 0x30.
- Store hit 0x10 with wdata 0x12345678, then load 0x10. Expect: rdata 0x12345678, dirty set, no mem traffic.
- Hold mem_req_ready=0 for 5 cycles during WB. Expect: mem_req_valid/addr/wdata stable, cpu_req_ready=0, no response.
- Assert rst_n=0 during REFILL wait. Expect: state IDLE, all valid=0, no cpu_resp_valid. A following load to the same address misses.
- Force hit0=hit1=1 in COMPARE. Expect: way0 data returned, LRU[set]=1.
